// File: rtl/mips_mem_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_pkg
// Shared types for the unified-memory port arbiter: FSM state encoding,
// transfer owner encoding and default bus widths.
// -----------------------------------------------------------------------------
package mips_mem_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT_IF = 2'd1,
      GNT_DM = 2'd2,
      RESP   = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_e;

   // Which requester a grant state belongs to.
   function automatic owner_e owner_of(input arb_state_e s);
      return (s == GNT_DM) ? OWN_DM : OWN_IF;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the Fetch handshake (if_*), the Memory-stage handshake (dm_*),
// the single-port memory request (mem_*) and the err/busy status.
//   slave  : the arbiter side (takes requests, drives acks and mem_*)
//   master : the environment side (pipeline stages plus memory model)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ack;
   logic [DATA_W-1:0] if_rdata;

   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_ack;
   logic [DATA_W-1:0] dm_rdata;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   logic              err;
   logic              busy;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
      output if_ack, if_rdata, dm_ack, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata,
             err, busy
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
      input  if_ack, if_rdata, dm_ack, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata,
             err, busy
   );
endinterface

// File: rtl/mem_arb_timer.sv
// -----------------------------------------------------------------------------
// mem_arb_timer
// Wait counter for an outstanding memory request. Counts edges on which the
// memory has not answered and flags when the next such edge must abort.
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_clr    : clear count to 0 (held while the arbiter is idle)
//   i_inc    : count one more wait edge
//   o_expire : count has reached TIMEOUT-1 (never asserted when TIMEOUT=0)
// -----------------------------------------------------------------------------
module mem_arb_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_expire
);
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic [CNT_W-1:0] r_cnt;

   // Saturates so a disabled timeout (TIMEOUT=0) never wraps around.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_cnt <= '0;
      else if (i_clr)
         r_cnt <= '0;
      else if (i_inc && (r_cnt != '1))
         r_cnt <= r_cnt + 1'b1;
   end

   assign o_expire = (TIMEOUT != 0) && (r_cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory between instruction fetch (IF) and the
// memory stage (DM). Data wins ties, but after MAX_DM_STREAK consecutive data
// grants with fetch waiting, fetch is served. Each transfer is
// IDLE -> GNT_x -> RESP -> IDLE; a wait longer than TIMEOUT edges aborts
// with err.
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : handshake/memory bundle (slave modport)
// -----------------------------------------------------------------------------
module mem_port_arbiter
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W        = DEF_ADDR_W,
   parameter int DATA_W        = DEF_DATA_W,
   parameter int MAX_DM_STREAK = 4,
   parameter int TIMEOUT       = 255
) (
   input  logic                clock,
   input  logic                reset,
   mem_port_arbiter_if.slave   bus
);
   localparam int STRK_W = $clog2(MAX_DM_STREAK + 1);
   localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(MAX_DM_STREAK);

   arb_state_e        r_state;
   logic [STRK_W-1:0] r_streak;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_if_ack;
   logic              r_dm_ack;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_dm_rdata;
   logic              r_err;
   logic              r_busy;

   logic              w_gnt_dm;
   logic              w_in_gnt;
   logic              w_expire;
   logic              w_done;
   logic              w_tmr_clr;
   logic              w_tmr_inc;
   logic [DATA_W-1:0] w_xfer_rdata;

   // Data wins unless fetch is waiting and the data streak is used up.
   assign w_gnt_dm     = bus.dm_req && (!bus.if_req || (r_streak < STRK_MAX));
   assign w_in_gnt     = (r_state == GNT_IF) || (r_state == GNT_DM);
   assign w_done       = w_in_gnt && (bus.mem_ready || w_expire);
   assign w_tmr_clr    = (r_state == IDLE);
   assign w_tmr_inc    = w_in_gnt && !bus.mem_ready;
   // Writes and aborted transfers return zero data.
   assign w_xfer_rdata = (bus.mem_ready && !r_mem_we) ? bus.mem_rdata : '0;

   mem_arb_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .i_clk    (clock),
      .i_rst_n  (reset),
      .i_clr    (w_tmr_clr),
      .i_inc    (w_tmr_inc),
      .o_expire (w_expire)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_streak    <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_if_ack    <= 1'b0;
         r_dm_ack    <= 1'b0;
         r_if_rdata  <= '0;
         r_dm_rdata  <= '0;
         r_err       <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_if_ack <= 1'b0;
         r_dm_ack <= 1'b0;
         r_err    <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_gnt_dm) begin
                  r_state     <= GNT_DM;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= bus.dm_we;
                  r_mem_addr  <= bus.dm_addr;
                  r_mem_wdata <= bus.dm_wdata;
                  r_busy      <= 1'b1;
                  // Only a streak that actually delays fetch is counted.
                  if (!bus.if_req)
                     r_streak <= '0;
                  else if (r_streak != STRK_MAX)
                     r_streak <= r_streak + 1'b1;
               end else if (bus.if_req) begin
                  r_state     <= GNT_IF;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b0;
                  r_mem_addr  <= bus.if_addr;
                  r_mem_wdata <= '0;
                  r_busy      <= 1'b1;
                  r_streak    <= '0;
               end
            end
            GNT_IF, GNT_DM: begin
               if (w_done) begin
                  r_state   <= RESP;
                  r_mem_req <= 1'b0;
                  r_err     <= !bus.mem_ready;
                  if (owner_of(r_state) == OWN_DM) begin
                     r_dm_ack   <= 1'b1;
                     r_dm_rdata <= w_xfer_rdata;
                  end else begin
                     r_if_ack   <= 1'b1;
                     r_if_rdata <= w_xfer_rdata;
                  end
               end
            end
            RESP: begin
               // No arbitration here: guarantees one idle cycle between transfers.
               r_state     <= IDLE;
               r_mem_we    <= 1'b0;
               r_mem_addr  <= '0;
               r_mem_wdata <= '0;
               r_busy      <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.if_ack    = r_if_ack;
   assign bus.if_rdata  = r_if_rdata;
   assign bus.dm_ack    = r_dm_ack;
   assign bus.dm_rdata  = r_dm_rdata;
   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.err       = r_err;
   assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed and randomized bench for mem_port_arbiter. The bench plays both
// pipeline stages and the memory; a transaction-level model (pending flags,
// a data-streak count and an associative memory) predicts every grant,
// ack and data word.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
   localparam int MAXS = 4;
   localparam int TMO  = 8;

   logic clk;
   logic rst_n;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(
      .ADDR_W        (32),
      .DATA_W        (32),
      .MAX_DM_STREAK (MAXS),
      .TIMEOUT       (TMO)
   ) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   // Reference model state
   bit          if_pend;
   bit          dm_pend;
   logic [31:0] if_a;
   logic [31:0] dm_a;
   logic [31:0] dm_wd;
   bit          dm_w;
   int          streak_m;
   logic [31:0] memm [logic [31:0]];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (memm.exists(a))
         return memm[a];
      return {a[15:0], ~a[15:0]};
   endfunction

   task automatic raise_if(input logic [31:0] a);
      if_pend     = 1'b1;
      if_a        = a;
      bus.if_req  = 1'b1;
      bus.if_addr = a;
   endtask

   task automatic raise_dm(input bit we, input logic [31:0] a, input logic [31:0] wd);
      dm_pend      = 1'b1;
      dm_w         = we;
      dm_a         = a;
      dm_wd        = wd;
      bus.dm_req   = 1'b1;
      bus.dm_we    = we;
      bus.dm_addr  = a;
      bus.dm_wdata = wd;
   endtask

   // One complete transfer starting from IDLE: grant, `waits` edges without
   // mem_ready, then completion (or abort when tmo=1), then back to IDLE.
   task automatic run_xfer(input int waits, input bit tmo, output bit got_dm);
      bit          w_dm;
      bit          ewe;
      logic [31:0] ea, ewd, rd, erd;
      w_dm = dm_pend && (!if_pend || streak_m < MAXS);
      if (w_dm)
         streak_m = if_pend ? ((streak_m < MAXS) ? streak_m + 1 : MAXS) : 0;
      else
         streak_m = 0;
      ea  = w_dm ? dm_a : if_a;
      ewe = w_dm ? dm_w : 1'b0;
      ewd = w_dm ? dm_wd : 32'h0;

      tick();
      chk("grant_req", bus.mem_req, 1'b1);
      chk("grant_addr", bus.mem_addr, ea);
      chk("grant_we", bus.mem_we, ewe);
      chk("grant_wdata", bus.mem_wdata, ewd);
      chk("grant_busy", bus.busy, 1'b1);
      chk("grant_noack", {bus.if_ack, bus.dm_ack, bus.err}, 3'b000);

      for (int i = 0; i < waits; i++) begin
         bus.mem_ready = 1'b0;
         bus.mem_rdata = $urandom;
         if (w_dm) begin
            bus.dm_addr  = $urandom;
            bus.dm_wdata = $urandom;
            bus.dm_we    = ~bus.dm_we;
         end else begin
            bus.if_addr = $urandom;
         end
         tick();
         chk("hold_bus", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata},
             {1'b1, ewe, ea, ewd});
         chk("hold_noack", {bus.if_ack, bus.dm_ack, bus.err}, 3'b000);
      end

      rd  = mem_val(ea);
      erd = (tmo || ewe) ? 32'h0 : rd;
      bus.mem_ready = !tmo;
      bus.mem_rdata = (tmo || ewe) ? ($urandom | 32'h1) : rd;
      tick();
      chk("ack_if", bus.if_ack, !w_dm);
      chk("ack_dm", bus.dm_ack, w_dm);
      chk("ack_err", bus.err, tmo);
      chk("ack_rdata", w_dm ? bus.dm_rdata : bus.if_rdata, erd);
      chk("ack_memreq", bus.mem_req, 1'b0);
      got_dm = bus.dm_ack;
      if (ewe && !tmo)
         memm[ea] = ewd;

      bus.mem_ready = 1'b0;
      if (w_dm) begin
         dm_pend    = 1'b0;
         bus.dm_req = 1'b0;
      end else begin
         if_pend    = 1'b0;
         bus.if_req = 1'b0;
      end
      tick();
      chk("idle_ctrl", {bus.if_ack, bus.dm_ack, bus.err, bus.busy, bus.mem_req}, 5'b0);
      chk("idle_bus", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 65'h0);
      chk("rdata_hold", w_dm ? bus.dm_rdata : bus.if_rdata, erd);
   endtask

   initial begin
      bit       g;
      bit [5:0] seq;
      clk = 1'b0;
      rst_n = 1'b0;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
      bus.mem_rdata = '0; bus.mem_ready = 1'b0;
      if_pend = 1'b0; dm_pend = 1'b0; streak_m = 0;
      if_a = '0; dm_a = '0; dm_wd = '0; dm_w = 1'b0;

      // Reset state
      repeat (3) tick();
      chk("rst_ctrl", {bus.if_ack, bus.dm_ack, bus.err, bus.busy, bus.mem_req, bus.mem_we}, 6'b0);
      chk("rst_bus", {bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.dm_rdata}, 128'h0);
      rst_n = 1'b1;
      tick();
      chk("idle_after_rst", {bus.busy, bus.mem_req}, 2'b00);

      // IF read, memory answers one cycle after mem_req
      memm[32'h400] = 32'h8C010004;
      raise_if(32'h400);
      run_xfer(1, 1'b0, g);
      chk("if_read_owner", g, 1'b0);
      chk("if_read_data", bus.if_rdata, 32'h8C010004);

      // Simultaneous requests: DM write first, IF after one idle cycle
      raise_if(32'h1040);
      raise_dm(1'b1, 32'h100, 32'hDEADBEEF);
      run_xfer(0, 1'b0, g);
      chk("tie_first_dm", g, 1'b1);
      chk("tie_dm_rdata", bus.dm_rdata, 32'h0);
      chk("tie_if_waiting", bus.mem_req, 1'b0);
      run_xfer(0, 1'b0, g);
      chk("tie_then_if", g, 1'b0);

      // Starvation guard: IF held, DM reissued continuously
      raise_if(32'h1200);
      for (int i = 0; i < 6; i++) begin
         if (!dm_pend) raise_dm(1'(i % 2), 32'h100 + 32'(i * 4), $urandom);
         run_xfer(i % 3, 1'b0, g);
         seq[i] = g;
      end
      chk("streak_order", seq, 6'b101111);

      // Timeout: memory never answers
      raise_if(32'h1300);
      run_xfer(TMO - 1, 1'b1, g);
      chk("timeout_owner", g, 1'b0);

      // Reset in the middle of a data transfer
      raise_dm(1'b0, 32'h100, 32'h0);
      run_xfer(0, 1'b0, g);
      chk("pre_rst_read", bus.dm_rdata, 32'hDEADBEEF);
      raise_dm(1'b0, 32'h44, 32'h0);
      tick();
      chk("mid_grant", {bus.mem_req, bus.busy}, 2'b11);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst", {bus.mem_req, bus.busy, bus.dm_ack, bus.mem_we}, 4'b0);
      chk("async_rst_data", {bus.mem_addr, bus.dm_rdata, bus.if_rdata}, 96'h0);
      bus.mem_ready = 1'b1;
      tick();
      chk("rst_no_ack", {bus.dm_ack, bus.if_ack, bus.mem_req}, 3'b0);
      bus.mem_ready = 1'b0;
      rst_n = 1'b1;
      streak_m = 0;
      run_xfer(2, 1'b0, g);
      chk("regrant_dm", g, 1'b1);

      // Randomized traffic with wait states 0..5
      for (int it = 0; it < 80; it++) begin
         if (!if_pend && ($urandom_range(0, 1) != 0))
            raise_if(32'h1000 + 32'($urandom_range(0, 15) * 4));
         if (!dm_pend && ($urandom_range(0, 2) != 0))
            raise_dm(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15) * 4), $urandom);
         if (if_pend || dm_pend)
            run_xfer(int'($urandom_range(0, 5)), 1'b0, g);
         else begin
            tick();
            chk("idle_quiet", {bus.busy, bus.mem_req, bus.if_ack, bus.dm_ack}, 4'b0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port unified memory between the Fetch stage (instruction reads) and the Memory stage (data reads and writes). Uses per-requester req/ack handshakes and a registered request to the memory, which may take a variable number of cycles. Data requests win a tie, limited by a starvation guard so instruction fetch always progresses. A bounded wait timeout raises an error. Sits at top level between the Fetch and Memory stages and the memory model; its ack outputs drive the pipeline stall logic.

Parameters:
ADDR_W, 32, address width of all address ports
DATA_W, 32, data width of all data ports
MAX_DM_STREAK, 4, max consecutive data grants while an instruction request waits (>=1)
TIMEOUT, 255, max cycles waiting for mem_ready before abort; 0 disables timeout

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  instruction read request, held until if_ack
if_addr  in  ADDR_W  instruction address, stable while if_req
if_ack  out  1  one-cycle pulse: instruction transfer done
if_rdata  out  DATA_W  instruction word, valid when if_ack
dm_req  in  1  data request, held until dm_ack
dm_we  in  1  1 = write, 0 = read; stable while dm_req
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  write data
dm_ack  out  1  one-cycle pulse: data transfer done
dm_rdata  out  DATA_W  read data, valid when dm_ack; 0 for writes
mem_req  out  1  memory request, held until mem_ready sampled
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
mem_ready  in  1  memory completes the current request on this edge
err  out  1  one-cycle pulse with ack when a transfer timed out
busy  out  1  state != IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs 0, including if_ack, dm_ack, rdata, mem_*, err and busy. Streak and timer counters are 0. An in-flight transfer is dropped with no ack. mem_req falls immediately.
- States: IDLE, GNT_IF, GNT_DM, RESP.
- IDLE arbitration on each edge:
  - Grant DM if dm_req=1 and (if_req=0 or streak<MAX_DM_STREAK).
  - Otherwise grant IF if if_req=1.
  - Otherwise stay in IDLE.
- On a grant edge: latch addr, we and wdata into mem_*; set mem_req=1. For IF, mem_we=0 and mem_wdata=0. Clear the timer.
- Streak counter:
  - On a DM grant with if_req=1: increment, saturating at MAX_DM_STREAK.
  - On a DM grant with if_req=0: clear to 0.
  - On an IF grant: clear to 0.
- GNT_x: mem_* held stable. Timer increments each edge with mem_ready=0.
  - Edge with mem_ready=1: latch mem_rdata into x_rdata (0 if write); drop mem_req; go to RESP; assert x_ack.
  - TIMEOUT!=0 and timer reaches TIMEOUT-1 with mem_ready=0: same as above, but rdata=0 and err=1.
- RESP (exactly one cycle):
  - x_ack=1 and err as set.
  - No arbitration in RESP. Next edge: ack, err and mem_* go to 0; go to IDLE.
  - A requester still holding req in the following IDLE cycle is treated as a new request.
- Latency: req high before edge E0 → mem_req high after E0. mem_ready high before E1 → ack high E1..E2. Minimum req-to-ack is 2 edges, and one idle cycle separates back-to-back transfers.
- Simultaneous requests always resolve deterministically; with MAX_DM_STREAK=4, an IF wait is bounded to 4 DM transfers.
- x_rdata holds its value after the ack until the next ack for that port.
- Changes on requester inputs during GNT/RESP have no effect on mem_*.

Decomposition:
- Shared package mips_mem_pkg: state enum (IDLE=2'd0, GNT_IF=2'd1, GNT_DM=2'd2, RESP=2'd3), owner encoding (OWN_IF, OWN_DM), default widths.
- One sub-module mem_arb_timer: loadable/clearable wait counter with TIMEOUT compare and disable-at-0. Arbitration, streak counter and FSM stay in mem_port_arbiter.

Test Plan:
- IF read, mem_ready one cycle after mem_req, mem_rdata=0x8C010004 → if_ack pulses 1 cycle 2 edges after the grant edge; if_rdata=0x8C010004; err=0.
- if_req and dm_req (write, addr 0x100, wdata 0xDEADBEEF) rise together → DM served first with mem_we=1, mem_addr=0x100, dm_rdata=0; IF served next after one IDLE cycle.
- if_req held, dm_req reissued continuously, MAX_DM_STREAK=4 → exactly 4 dm_acks, then if_ack, then DM resumes.
- mem_ready held 0, TIMEOUT=8 → ack and err pulse together 8 edges after the grant; rdata=0; mem_req drops; busy returns to 0.
- reset low mid GNT_DM → mem_req, busy and counters go to 0 immediately with no dm_ack. After release, a held dm_req is re-granted from IDLE.
- Wait states 0..5 on random mem_ready → mem_addr, mem_we and mem_wdata stay stable while mem_req=1 even when requester inputs change.
